// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Purpose  : Round-robin sharing of the UART transmit path between two byte
//             sources (req 0 = 6809 monitor, req 1 = debug engine). Issues the
//             UART write strobe and follows the UART TX-busy status bit so that
//             each frame completes before the next byte is written.
//  Options  : TXSCHED_TIMEOUT_EN - abort a stuck transfer after TIMEOUT_CYCLES
//             and pulse o_err (2**CNT_W must exceed TIMEOUT_CYCLES).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  output logic [1:0] o_ack,
  output logic       o_uart_ce,
  output logic       o_uart_rw,
  output logic [7:0] o_uart_wdata,
  input  logic [7:0] i_uart_status,
  output logic       o_busy,
  output logic       o_last_grant,
  output logic       o_err
);

  localparam logic [1:0] c_st_idle       = 2'd0;
  localparam logic [1:0] c_st_write      = 2'd1;
  localparam logic [1:0] c_st_wait_start = 2'd2;
  localparam logic [1:0] c_st_wait_done  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] settle_q, settle_d;
  logic [7:0] wdata_q, wdata_d;
  logic       last_q, last_d;

  logic       w_busy_s;
  logic       w_grant;
  logic       w_can_grant;
  logic       w_timeout;
  logic       w_in_wait;

  // Only the TX-busy bit of the status register is meaningful here.
  logic       w_unused_status;
  assign w_unused_status = &{1'b0, i_uart_status[7:2], i_uart_status[0]};

  assign w_busy_s  = sync2_q;
  assign w_in_wait = (state_q == c_st_wait_start) || (state_q == c_st_wait_done);

  // Round-robin pick: a lone request wins outright, a tie goes away from the last grant.
  always_comb begin
    w_grant = i_req[1];
    if (i_req == 2'b11) begin
      w_grant = ~last_q;
    end
  end

  // The synchronizer restarts from 0 on reset, so a grant is held off until it
  // has refilled; otherwise a UART still busy with a pre-reset frame would be
  // seen as idle for two cycles.
  assign w_can_grant = (state_q == c_st_idle) && settle_q[1] && !w_busy_s && (i_req != 2'b00);

  // Next-value logic for the synchronizer, settle shifter and captured byte.
  always_comb begin
    sync1_d  = i_uart_status[1];
    sync2_d  = sync1_q;
    settle_d = {settle_q[0], 1'b1};
    wdata_d  = wdata_q;
    last_d   = last_q;
    if (w_can_grant) begin
      wdata_d = w_grant ? i_data1 : i_data0;
      last_d  = w_grant;
    end
  end

`ifdef TXSCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Timeout counter: cleared while writing, runs through both wait states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == c_st_write) begin
      cnt_d = '0;
    end else if (w_in_wait) begin
      cnt_d = cnt_q + c_cnt_one;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign w_timeout = w_in_wait && (cnt_q == c_cnt_last);
`else
  // Keeps the timeout parameters referenced when the feature is compiled out.
  logic [CNT_W-1:0] w_unused_cfg;
  assign w_unused_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= c_st_idle;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      settle_q <= 2'b00;
      wdata_q  <= 8'h00;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      settle_q <= settle_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
    end
  end

  // Next-state logic: grant, one strobe cycle, then follow the UART busy bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_st_idle: begin
        if (w_can_grant) state_d = c_st_write;
      end
      c_st_write: begin
        state_d = c_st_wait_start;
      end
      c_st_wait_start: begin
        if (w_timeout)     state_d = c_st_idle;
        else if (w_busy_s) state_d = c_st_wait_done;
      end
      c_st_wait_done: begin
        if (w_timeout || !w_busy_s) state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Output decode: strobe and ack only in WRITE, error only on a wait-state abort.
  always_comb begin
    o_ack     = 2'b00;
    o_uart_ce = 1'b0;
    o_uart_rw = 1'b1;
    o_err     = 1'b0;
    unique case (state_q)
      c_st_write: begin
        o_uart_ce = 1'b1;
        o_uart_rw = 1'b0;
        o_ack     = last_q ? 2'b10 : 2'b01;
      end
      c_st_wait_start, c_st_wait_done: begin
        o_err = w_timeout;
      end
      default: begin
        o_err = 1'b0;
      end
    endcase
  end

  assign o_busy       = (state_q != c_st_idle);
  assign o_last_grant = last_q;
  assign o_uart_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_scheduler
//  Purpose  : Self-checking bench for uart_tx_scheduler with a behavioural
//             UART busy model and a write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int FRAME_CYCLES   = 1040;
  localparam int TIMEOUT_CYCLES = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] i_req;
  logic [7:0] i_data0, i_data1;
  logic [1:0] o_ack;
  logic       o_uart_ce, o_uart_rw, o_busy, o_last_grant, o_err;
  logic [7:0] o_uart_wdata;
  logic [7:0] uart_status;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_writes = 0;
  logic [9:0] exp_q[$];

  // UART model state
  int   frame_left = 0;
  logic force_busy = 1'b0;
  logic no_busy    = 1'b0;
  logic status_busy;

  uart_tx_scheduler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_data0(i_data0), .i_data1(i_data1),
    .o_ack(o_ack), .o_uart_ce(o_uart_ce), .o_uart_rw(o_uart_rw), .o_uart_wdata(o_uart_wdata),
    .i_uart_status(uart_status), .o_busy(o_busy), .o_last_grant(o_last_grant), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // UART model: a write starts a frame that keeps TX-busy high for FRAME_CYCLES.
  always @(posedge clk) begin
    if (o_uart_ce && !o_uart_rw && !no_busy) frame_left <= FRAME_CYCLES;
    else if (frame_left > 0)                 frame_left <= frame_left - 1;
  end
  assign status_busy = (frame_left > 0) || force_busy;
  assign uart_status = {6'b101010, status_busy, 1'b1};

  // Scoreboard: every UART write pops one expected {ack, byte}.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (o_uart_ce && !o_uart_rw) begin
        n_writes++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got ack=%b data=%h, required no write", o_ack, o_uart_wdata);
        end else begin
          exp = exp_q.pop_front();
          if ({o_ack, o_uart_wdata} !== exp)
            begin
              n_bad++;
              $display("FAIL write_data: got ack=%b data=%h, required ack=%b data=%h",
                       o_ack, o_uart_wdata, exp[9:8], exp[7:0]);
            end
        end
      end else if (o_ack !== 2'b00) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack_without_strobe: got ack=%b, required 00", o_ack);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_writes < target && k < budget) begin step(); k++; end
    ok = (n_writes >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while ((o_busy || status_busy) && k < budget) begin step(); k++; end
    ok = !(o_busy || status_busy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 2'b00;
    repeat (3) step();
    n_cmp++; if (o_ack !== 2'b00)     begin n_bad++; $display("FAIL rst_ack: got %b, required 00", o_ack); end
    n_cmp++; if (o_uart_ce !== 1'b0)  begin n_bad++; $display("FAIL rst_ce: got %b, required 0", o_uart_ce); end
    n_cmp++; if (o_uart_rw !== 1'b1)  begin n_bad++; $display("FAIL rst_rw: got %b, required 1", o_uart_rw); end
    n_cmp++; if (o_uart_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got %h, required 00", o_uart_wdata); end
    n_cmp++; if (o_busy !== 1'b0)     begin n_bad++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    n_cmp++; if (o_last_grant !== 1'b1) begin n_bad++; $display("FAIL rst_last_grant: got %b, required 1", o_last_grant); end
    n_cmp++; if (o_err !== 1'b0)      begin n_bad++; $display("FAIL rst_err: got %b, required 0", o_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    bit ok;
    int k;
    i_data0 = 8'h41;
    i_req   = 2'b01;
    exp_q.push_back({2'b01, 8'h41});
    wait_writes(n_writes + 1, 20, ok);
    i_req = 2'b00;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_write: got no write, required one"); end
    n_cmp++; if (o_ack !== 2'b00) begin n_bad++; $display("FAIL ack_width: got %b a cycle later, required 00", o_ack); end
    n_cmp++; if (o_last_grant !== 1'b0) begin n_bad++; $display("FAIL single_last_grant: got %b, required 0", o_last_grant); end
    k = 0;
    while (status_busy && k < FRAME_CYCLES + 20) begin step(); k++; end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL busy_at_frame_end: got %b, required 1", o_busy); end
    k = 0;
    while (o_busy && k < 10) begin step(); k++; end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL busy_fall_latency: got %0d cycles, required 3", k); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int base;
    base    = n_writes;
    i_data0 = 8'hA0;
    i_data1 = 8'hB1;
    i_req   = 2'b11;
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB1});
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB1});
    wait_writes(base + 4, 4 * (FRAME_CYCLES + 30), ok);
    i_req = 2'b00;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_writes: got %0d writes, required 4", n_writes - base); end
    n_cmp++; if (o_last_grant !== 1'b1) begin n_bad++; $display("FAIL rr_last_grant: got %b, required 1", o_last_grant); end
    wait_idle(FRAME_CYCLES + 30, ok);
    n_cmp++; if (exp_q.size() != 0 || n_writes != base + 4)
      begin n_bad++; $display("FAIL rr_extra: got %0d writes, required 4", n_writes - base); end
  endtask

  task automatic test_busy_block();
    bit ok;
    bit saw_ce;
    int base;
    int k;
    wait_idle(FRAME_CYCLES + 30, ok);
    force_busy = 1'b1;
    repeat (5) step();
    base    = n_writes;
    i_data1 = 8'hC3;
    i_req   = 2'b10;
    exp_q.push_back({2'b10, 8'hC3});
    saw_ce = 1'b0;
    repeat (30) begin step(); if (o_uart_ce || o_ack != 2'b00) saw_ce = 1'b1; end
    n_cmp++; if (saw_ce || n_writes != base) begin n_bad++; $display("FAIL blocked_grant: got ce/ack while busy, required none"); end
    force_busy = 1'b0;
    k = 0;
    while (o_ack == 2'b00 && k < 10) begin step(); k++; end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL unblock_latency: got %0d cycles, required 3", k); end
    i_req = 2'b00;
    wait_idle(FRAME_CYCLES + 30, ok);
  endtask

  task automatic test_ignore_during_frame();
    bit ok;
    int base;
    int k;
    base    = n_writes;
    i_data0 = 8'h55;
    i_req   = 2'b01;
    exp_q.push_back({2'b01, 8'h55});
    wait_writes(base + 1, 20, ok);
    i_req = 2'b00;
    repeat (10) step();
    i_data0 = 8'h66;
    i_req   = 2'b01;
    exp_q.push_back({2'b01, 8'h66});
    k = 0;
    while (status_busy && k < FRAME_CYCLES + 20) begin step(); k++; end
    n_cmp++; if (n_writes != base + 1) begin n_bad++; $display("FAIL mid_frame_ack: got %0d writes, required 1", n_writes - base); end
    wait_writes(base + 2, 20, ok);
    i_req = 2'b00;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL post_frame_write: got no write, required one"); end
    repeat (2 * FRAME_CYCLES) step();
    n_cmp++; if (n_writes != base + 2 || exp_q.size() != 0)
      begin n_bad++; $display("FAIL no_second_write: got %0d writes, required 2", n_writes - base); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int k;
    wait_idle(FRAME_CYCLES + 30, ok);
    base    = n_writes;
    i_data0 = 8'h77;
    i_req   = 2'b01;
    exp_q.push_back({2'b01, 8'h77});
    wait_writes(base + 1, 20, ok);
    i_req = 2'b00;
    repeat (10) step();
    reset = 1'b1;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b, required 0", o_busy); end
    n_cmp++; if (o_uart_rw !== 1'b1 || o_uart_ce !== 1'b0)
      begin n_bad++; $display("FAIL midrst_rw_ce: got rw=%b ce=%b, required rw=1 ce=0", o_uart_rw, o_uart_ce); end
    n_cmp++; if (o_ack !== 2'b00) begin n_bad++; $display("FAIL midrst_ack: got %b, required 00", o_ack); end
    step();
    step();
    reset   = 1'b0;
    i_data0 = 8'h12;
    i_req   = 2'b01;
    exp_q.push_back({2'b01, 8'h12});
    k = 0;
    while (status_busy && k < FRAME_CYCLES + 20) begin step(); k++; end
    n_cmp++; if (n_writes != base + 1) begin n_bad++; $display("FAIL grant_while_busy_after_reset: got %0d writes, required 1", n_writes - base); end
    wait_writes(base + 2, 20, ok);
    i_req = 2'b00;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL write_after_reset: got no write, required one"); end
    wait_idle(FRAME_CYCLES + 30, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    bit saw_err;
    bit dropped;
    wait_idle(FRAME_CYCLES + 30, ok);
    no_busy = 1'b1;
    i_data0 = 8'h99;
    i_req   = 2'b01;
    exp_q.push_back({2'b01, 8'h99});
    k = 0;
    while (o_ack == 2'b00 && k < 20) begin step(); k++; end
    i_req = 2'b00;
    n_cmp++; if (o_ack !== 2'b01) begin n_bad++; $display("FAIL timeout_write: got ack=%b, required 01", o_ack); end
`ifdef TXSCHED_TIMEOUT_EN
    k = 0;
    while (!o_err && k < TIMEOUT_CYCLES + 100) begin step(); k++; end
    n_cmp++; if (k != TIMEOUT_CYCLES) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles, required %0d", k, TIMEOUT_CYCLES); end
    step();
    n_cmp++; if (o_err !== 1'b0 || o_busy !== 1'b0)
      begin n_bad++; $display("FAIL timeout_abort: got err=%b busy=%b, required 0 0", o_err, o_busy); end
`else
    saw_err = 1'b0;
    dropped = 1'b0;
    repeat (TIMEOUT_CYCLES + 200) begin
      step();
      if (o_err) saw_err = 1'b1;
      if (!o_busy) dropped = 1'b1;
    end
    n_cmp++; if (saw_err) begin n_bad++; $display("FAIL no_timeout_err: got err pulse, required none"); end
    n_cmp++; if (dropped) begin n_bad++; $display("FAIL no_timeout_busy: got busy=0, required stay 1"); end
`endif
    no_busy = 1'b0;
    test_reset();
  endtask

  initial begin
    reset   = 1'b1;
    i_req   = 2'b00;
    i_data0 = 8'h00;
    i_data1 = 8'h00;
    test_reset();
    test_single();
    test_reset();
    test_round_robin();
    test_busy_block();
    test_ignore_during_frame();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
